// File: rtl/udp_loop_pkg.sv
// Shared definitions for the UDP loopback echo buffer: FSM encoding,
// counter limits and a small saturating-increment helper.
package udp_loop_pkg;

    // Echo FSM encoding.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        START    = 2'd2,
        SEND     = 2'd3
    } state_t;

    // Saturation value of the dropped-frame counter.
    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    // Increment v by one unless it already equals lim.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic [15:0] lim);
        return (v == lim) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/udp_loop_ram.sv
// Simple dual-port payload RAM: one write port, one registered read port.
// Written in the plain form that maps onto block RAM.
module udp_loop_ram #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/udp_loopback.sv
// Single-frame UDP echo buffer. Captures one received payload into RAM, then
// asks the eth core to transmit the same number of bytes and serves its
// byte requests from RAM. Frames that cannot be echoed are dropped and counted.
module udp_loopback
    import udp_loop_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic        udp_rx_data_vld,
    input  logic [7:0]  udp_rx_data,
    input  logic        udp_rx_done,
    input  logic [15:0] udp_rx_data_num,
    input  logic        tx_rdy,
    input  logic        udp_tx_req,
    output logic        udp_tx_en,
    output logic [15:0] udp_tx_data_num,
    output logic [7:0]  udp_tx_data,
    output logic        frame_drop,
    output logic [15:0] drop_cnt
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);
    // wr_cnt parks one past DEPTH to remember that bytes were lost.
    localparam logic [15:0] WR_SAT  = DEPTH_W + 16'd1;

    state_t      state_q, state_d;
    logic [15:0] wr_cnt_q;
    logic [15:0] rd_cnt_q;
    logic [15:0] tx_num_q;
    logic [15:0] drop_cnt_q;
    logic        frame_drop_q;
    logic        rd_vld_q;

    logic        in_idle;
    logic        rx_byte;
    logic [15:0] wr_cnt_eff;
    logic        accept;
    logic        drop;
    logic        ram_we;
    logic        rd_hit;
    logic        send_done;
    logic [7:0]  ram_rdata;

    // Capture/accept/read decode shared by the FSM and the datapath.
    always_comb begin
        in_idle    = (state_q == IDLE);
        rx_byte    = in_idle & udp_rx_data_vld;
        // A byte arriving together with done is counted before the check.
        wr_cnt_eff = rx_byte ? sat_inc16(wr_cnt_q, WR_SAT) : wr_cnt_q;
        accept     = in_idle & udp_rx_done
                   & (udp_rx_data_num != 16'd0)
                   & (udp_rx_data_num <= wr_cnt_eff)
                   & (wr_cnt_eff <= DEPTH_W);
        drop       = udp_rx_done & ~accept;
        ram_we     = rx_byte & (wr_cnt_q < DEPTH_W);
        rd_hit     = (state_q == SEND) & udp_tx_req & (rd_cnt_q < tx_num_q);
        send_done  = (state_q == SEND) & (rd_cnt_q == tx_num_q);
    end

    // FSM state register.
    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (accept) state_d = WAIT_RDY;
            WAIT_RDY: if (tx_rdy) state_d = START;
            START:    state_d = SEND;
            SEND:     if (send_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs: transmit start pulse lasts exactly the START cycle.
    always_comb begin
        udp_tx_en = (state_q == START);
    end

    // Receive write counter: cleared on every done seen in IDLE.
    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            wr_cnt_q <= 16'd0;
        end else if (in_idle && udp_rx_done) begin
            wr_cnt_q <= 16'd0;
        end else if (rx_byte) begin
            wr_cnt_q <= sat_inc16(wr_cnt_q, WR_SAT);
        end
    end

    // Echo length, latched on accept and held through SEND.
    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            tx_num_q <= 16'd0;
        end else if (accept) begin
            tx_num_q <= udp_rx_data_num;
        end
    end

    // Transmit read counter: restarted in START, advanced per served request.
    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            rd_cnt_q <= 16'd0;
        end else if (state_q == START) begin
            rd_cnt_q <= 16'd0;
        end else if (rd_hit) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    // Marks that the RAM output register holds a requested payload byte;
    // otherwise the data output is forced to zero.
    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_hit;
        end
    end

    // Drop pulse and saturating drop counter, both one cycle after done.
    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            frame_drop_q <= 1'b0;
            drop_cnt_q   <= 16'd0;
        end else begin
            frame_drop_q <= drop;
            if (drop) begin
                drop_cnt_q <= sat_inc16(drop_cnt_q, DROP_MAX);
            end
        end
    end

    udp_loop_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (gmii_rx_clk),
        .we    (ram_we),
        .waddr (wr_cnt_q[ADDR_W-1:0]),
        .wdata (udp_rx_data),
        .re    (rd_hit),
        .raddr (rd_cnt_q[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // Output assignments.
    always_comb begin
        udp_tx_data     = rd_vld_q ? ram_rdata : 8'h00;
        udp_tx_data_num = tx_num_q;
        frame_drop      = frame_drop_q;
        drop_cnt        = drop_cnt_q;
    end

endmodule

// File: tb/tb_udp_loopback.sv
// Scoreboard bench for udp_loopback: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_udp_loopback;

    localparam int DEPTH = 2048;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        int num;
        int cyc;
    } en_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        udp_rx_data_vld = 1'b0;
    logic [7:0]  udp_rx_data = 8'h00;
    logic        udp_rx_done = 1'b0;
    logic [15:0] udp_rx_data_num = 16'd0;
    logic        tx_rdy = 1'b0;
    logic        udp_tx_req = 1'b0;
    logic        udp_tx_en;
    logic [15:0] udp_tx_data_num;
    logic [7:0]  udp_tx_data;
    logic        frame_drop;
    logic [15:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic req_d = 1'b0;

    // Reference model state.
    bit      busy = 0;
    bytes_t  echo_mem;
    int      echo_len = 0;
    int      model_drop = 0;
    en_exp_t en_q[$];
    int      drop_q[$];
    int      data_q[$];

    udp_loopback #(
        .ADDR_W (11)
    ) dut (
        .gmii_rx_clk     (clk),
        .rst             (rst),
        .udp_rx_data_vld (udp_rx_data_vld),
        .udp_rx_data     (udp_rx_data),
        .udp_rx_done     (udp_rx_done),
        .udp_rx_data_num (udp_rx_data_num),
        .tx_rdy          (tx_rdy),
        .udp_tx_req      (udp_tx_req),
        .udp_tx_en       (udp_tx_en),
        .udp_tx_data_num (udp_tx_data_num),
        .udp_tx_data     (udp_tx_data),
        .frame_drop      (frame_drop),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        req_d <= udp_tx_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        if (udp_tx_en === 1'b1) begin
            if (en_q.size() == 0) begin
                check("unexpected_tx_en", 1, 0);
            end else begin
                en_exp_t e;
                e = en_q.pop_front();
                check("tx_data_num", 32'(udp_tx_data_num), e.num);
                if (e.cyc >= 0) check("tx_en_cycle", cyc, e.cyc);
            end
        end
        if (frame_drop === 1'b1) begin
            if (drop_q.size() == 0) begin
                check("unexpected_frame_drop", 1, 0);
            end else begin
                check("drop_cnt", 32'(drop_cnt), drop_q.pop_front());
            end
        end
        if (req_d) begin
            if (data_q.size() == 0) begin
                check("unexpected_req_data", 1, 0);
            end else begin
                check("tx_data", 32'(udp_tx_data), data_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame acceptance rule applied to a whole frame at once.
    task automatic model_rx(input bytes_t d, input int num, input int dcyc);
        int n;
        bit acc;
        n   = d.size();
        acc = !busy && num >= 1 && num <= n && n <= DEPTH;
        if (acc) begin
            en_exp_t e;
            busy     = 1;
            echo_mem = d;
            echo_len = num;
            e.num    = num;
            e.cyc    = tx_rdy ? dcyc + 2 : -1;
            en_q.push_back(e);
        end else begin
            if (model_drop < 65535) model_drop++;
            drop_q.push_back(model_drop);
        end
    endtask

    task automatic send_frame(input bytes_t d, input int num, input bit merge_last,
                              input bit gaps);
        int n;
        int dcyc;
        n    = d.size();
        dcyc = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                udp_rx_data_vld = 1'b0;
                tick();
            end
            udp_rx_data_vld = 1'b1;
            udp_rx_data     = d[i];
            if (merge_last && i == n - 1) begin
                udp_rx_done     = 1'b1;
                udp_rx_data_num = 16'(num);
                dcyc            = cyc;
            end
            tick();
        end
        udp_rx_data_vld = 1'b0;
        if (!merge_last || n == 0) begin
            udp_rx_done     = 1'b1;
            udp_rx_data_num = 16'(num);
            dcyc            = cyc;
            tick();
        end
        udp_rx_done = 1'b0;
        model_rx(d, num, dcyc);
    endtask

    // Plays the eth transmitter: wait for the start pulse, then issue requests.
    // rst_at >= 0 asserts reset together with that request.
    task automatic run_echo(input int n_req, input bit gaps, input int rst_at);
        int w;
        int idx;
        w = 0;
        while (udp_tx_en !== 1'b1 && w < 300) begin
            tick();
            w++;
        end
        if (udp_tx_en !== 1'b1) begin
            check("tx_en_timeout", 0, 1);
            busy = 0;
            return;
        end
        tick();
        idx = 0;
        for (int k = 0; k < n_req; k++) begin
            if (gaps && $urandom_range(2) == 0) begin
                udp_tx_req = 1'b0;
                tick();
            end
            udp_tx_req = 1'b1;
            if (k == rst_at) begin
                rst = 1'b1;
                data_q.push_back(0);
            end else begin
                data_q.push_back(idx < echo_len ? int'(echo_mem[idx]) : 0);
            end
            idx++;
            tick();
            if (k == rst_at) begin
                rst        = 1'b0;
                udp_tx_req = 1'b0;
                busy       = 0;
                model_drop = 0;
                check("rst_tx_en", 32'(udp_tx_en), 0);
                check("rst_tx_data_num", 32'(udp_tx_data_num), 0);
                check("rst_frame_drop", 32'(frame_drop), 0);
                check("rst_drop_cnt", 32'(drop_cnt), 0);
                check("rst_tx_data", 32'(udp_tx_data), 0);
                return;
            end
        end
        udp_tx_req = 1'b0;
        tick();
        busy = 0;
    endtask

    function automatic bytes_t rand_bytes(input int n);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
        return q;
    endfunction

    initial begin
        bytes_t d;
        int     n;
        int     num;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_tx_en", 32'(udp_tx_en), 0);
        check("reset_tx_data", 32'(udp_tx_data), 0);
        check("reset_tx_data_num", 32'(udp_tx_data_num), 0);
        check("reset_frame_drop", 32'(frame_drop), 0);
        check("reset_drop_cnt", 32'(drop_cnt), 0);

        // Basic echo, bytes 0x00..0x3F, back-to-back requests.
        tx_rdy = 1'b1;
        d = {};
        for (int i = 0; i < 64; i++) d.push_back(8'(i));
        send_frame(d, 64, 1'b0, 1'b0);
        run_echo(64, 1'b0, -1);

        // Padded frame: only the first 5 of 18 bytes are echoed.
        send_frame(rand_bytes(18), 5, 1'b0, 1'b1);
        run_echo(5, 1'b0, -1);

        // Reset at the 10th of 32 requests, then a 4-byte frame.
        send_frame(rand_bytes(32), 32, 1'b0, 1'b0);
        run_echo(32, 1'b0, 9);
        send_frame(rand_bytes(4), 4, 1'b0, 1'b0);
        run_echo(4, 1'b0, -1);

        // Overflow: 2100 bytes cannot be held.
        send_frame(rand_bytes(2100), 2100, 1'b0, 1'b0);
        repeat (4) tick();
        check("overflow_drop_cnt", 32'(drop_cnt), 1);

        // Busy drop: second frame arrives while waiting for tx_rdy.
        tx_rdy = 1'b0;
        send_frame(rand_bytes(20), 20, 1'b0, 1'b0);
        repeat (5) tick();
        send_frame(rand_bytes(10), 10, 1'b1, 1'b0);
        repeat (80) tick();
        check("busy_drop_cnt", 32'(drop_cnt), 32'(model_drop));
        tx_rdy = 1'b1;
        en_q[en_q.size()-1].cyc = cyc + 1;
        run_echo(20, 1'b1, -1);

        // Boundary: exactly DEPTH bytes with done on the last byte.
        send_frame(rand_bytes(DEPTH), DEPTH, 1'b1, 1'b0);
        run_echo(DEPTH, 1'b0, -1);

        // One byte past DEPTH overflows even for a short length.
        send_frame(rand_bytes(DEPTH + 1), 5, 1'b0, 1'b0);
        repeat (3) tick();

        // Excess requests, then an immediate new frame.
        send_frame(rand_bytes(12), 12, 1'b1, 1'b0);
        run_echo(15, 1'b0, -1);
        send_frame(rand_bytes(7), 7, 1'b0, 1'b0);
        run_echo(7, 1'b1, -1);

        // Randomized frames, lengths and rejects.
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, 120);
            case ($urandom_range(5))
                0:       num = 0;
                1:       num = n + $urandom_range(1, 3);
                default: num = $urandom_range(1, n);
            endcase
            send_frame(rand_bytes(n), num, 1'($urandom_range(1)), 1'($urandom_range(1)));
            if (busy) run_echo(num + $urandom_range(0, 2), 1'($urandom_range(1)), -1);
            else repeat (2) tick();
        end

        repeat (5) tick();
        check("final_drop_cnt", 32'(drop_cnt), 32'(model_drop));
        check("pending_tx_en", en_q.size(), 0);
        check("pending_drops", drop_q.size(), 0);
        check("pending_data", data_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
